// File: rtl/synth_mmio_ctrl.sv
// synth_mmio_ctrl: CPU-side MMIO shadow registers for the synth controls and
// the initiator of the 4-phase req/ack transfer into the synth clock domain.
// Shadows are freely writable. A commit copies them into the cpu_* outputs and
// raises cpu_req. The outputs then hold until the next launch.
module synth_mmio_ctrl #(
  parameter int N_VOICES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             mmio_addr,
  input  logic [31:0]            mmio_wdata,
  input  logic                   mmio_we,
  input  logic                   mmio_re,
  output logic [31:0]            mmio_rdata,
  output logic [24*N_VOICES-1:0] cpu_carrier_fcws,
  output logic [23:0]            cpu_mod_fcw,
  output logic [4:0]             cpu_mod_shift,
  output logic [N_VOICES-1:0]    cpu_note_en,
  output logic [4:0]             cpu_synth_shift,
  output logic                   cpu_req,
  input  logic                   cpu_ack
);

  // Word indices (byte offset / 4) of the fixed registers.
  localparam logic [5:0] IDX_MOD_FCW     = 6'd16;  // 0x40
  localparam logic [5:0] IDX_MOD_SHIFT   = 6'd17;  // 0x44
  localparam logic [5:0] IDX_NOTE_EN     = 6'd18;  // 0x48
  localparam logic [5:0] IDX_SYNTH_SHIFT = 6'd19;  // 0x4C
  localparam logic [5:0] IDX_COMMIT      = 6'd20;  // 0x50

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                   state_r;
  logic                     pending_r;
  logic [24*N_VOICES-1:0]   carrier_shadow_r;
  logic [23:0]              mod_fcw_shadow_r;
  logic [4:0]               mod_shift_shadow_r;
  logic [N_VOICES-1:0]      note_en_shadow_r;
  logic [4:0]               synth_shift_shadow_r;

  logic [5:0]               word_idx_s;
  logic                     commit_s;
  logic                     busy_s;
  logic                     launch_s;
  logic [31:0]              carrier_rd_s;
  logic [31:0]              rd_data_s;
  logic                     ignored_bits_unused_s;

  // Byte-lane bits and upper write-data bits carry no meaning for this block.
  assign ignored_bits_unused_s = ^{mmio_addr[1:0], mmio_wdata[31:24]};

  assign word_idx_s = mmio_addr[7:2];
  assign commit_s   = mmio_we && (word_idx_s == IDX_COMMIT);
  assign busy_s     = (state_r != ST_IDLE);

  // Decide whether this edge launches a transfer (fresh commit or queued relaunch).
  always_comb begin
    launch_s = 1'b0;
    case (state_r)
      ST_IDLE:    launch_s = commit_s;
      ST_REQ:     launch_s = 1'b0;
      // A commit arriving on the closing edge is folded into the relaunch.
      ST_RELEASE: launch_s = !cpu_ack && (pending_r || commit_s);
      default:    launch_s = 1'b0;
    endcase
  end

  // Shadow register writes; legal in every FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carrier_shadow_r     <= '0;
      mod_fcw_shadow_r     <= 24'd0;
      mod_shift_shadow_r   <= 5'd0;
      note_en_shadow_r     <= '0;
      synth_shift_shadow_r <= 5'd0;
    end else if (mmio_we) begin
      for (int i = 0; i < N_VOICES; i++) begin
        if (word_idx_s == 6'(i)) begin
          carrier_shadow_r[24*i +: 24] <= mmio_wdata[23:0];
        end
      end
      case (word_idx_s)
        IDX_MOD_FCW:     mod_fcw_shadow_r     <= mmio_wdata[23:0];
        IDX_MOD_SHIFT:   mod_shift_shadow_r   <= mmio_wdata[4:0];
        IDX_NOTE_EN:     note_en_shadow_r     <= mmio_wdata[N_VOICES-1:0];
        IDX_SYNTH_SHIFT: synth_shift_shadow_r <= mmio_wdata[4:0];
        default:         ;
      endcase
    end
  end

  // Select the addressed carrier shadow; zero when the index has no voice.
  always_comb begin
    carrier_rd_s = 32'd0;
    for (int i = 0; i < N_VOICES; i++) begin
      carrier_rd_s = (word_idx_s == 6'(i)) ? {8'd0, carrier_shadow_r[24*i +: 24]}
                                           : carrier_rd_s;
    end
  end

  // Read mux: zero-extended shadows, status word, zero for unmapped offsets.
  always_comb begin
    rd_data_s = 32'd0;
    case (word_idx_s)
      IDX_MOD_FCW:     rd_data_s = {8'd0, mod_fcw_shadow_r};
      IDX_MOD_SHIFT:   rd_data_s = {27'd0, mod_shift_shadow_r};
      IDX_NOTE_EN:     rd_data_s = 32'(note_en_shadow_r);
      IDX_SYNTH_SHIFT: rd_data_s = {27'd0, synth_shift_shadow_r};
      IDX_COMMIT:      rd_data_s = {30'd0, pending_r, busy_s};
      default:         rd_data_s = carrier_rd_s;
    endcase
  end

  // Registered read data; a simultaneous write suppresses the read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmio_rdata <= 32'd0;
    end else if (mmio_re && !mmio_we) begin
      mmio_rdata <= rd_data_s;
    end else begin
      mmio_rdata <= mmio_rdata;
    end
  end

  // Handshake FSM: launches latch the shadows into cpu_* and raise cpu_req.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      pending_r        <= 1'b0;
      cpu_req          <= 1'b0;
      cpu_carrier_fcws <= '0;
      cpu_mod_fcw      <= 24'd0;
      cpu_mod_shift    <= 5'd0;
      cpu_note_en      <= '0;
      cpu_synth_shift  <= 5'd0;
    end else if (launch_s) begin
      state_r          <= ST_REQ;
      pending_r        <= 1'b0;
      cpu_req          <= 1'b1;
      cpu_carrier_fcws <= carrier_shadow_r;
      cpu_mod_fcw      <= mod_fcw_shadow_r;
      cpu_mod_shift    <= mod_shift_shadow_r;
      cpu_note_en      <= note_en_shadow_r;
      cpu_synth_shift  <= synth_shift_shadow_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Stale ack is ignored here; only a commit leaves IDLE.
          state_r   <= ST_IDLE;
          pending_r <= 1'b0;
          cpu_req   <= 1'b0;
        end
        ST_REQ: begin
          pending_r <= pending_r | commit_s;
          if (cpu_ack) begin
            state_r <= ST_RELEASE;
            cpu_req <= 1'b0;
          end else begin
            state_r <= ST_REQ;
            cpu_req <= 1'b1;
          end
        end
        ST_RELEASE: begin
          cpu_req   <= 1'b0;
          pending_r <= pending_r | commit_s;
          if (!cpu_ack) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= 1'b0;
          cpu_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synth_mmio_ctrl.sv
// tb_synth_mmio_ctrl: self-checking bench for synth_mmio_ctrl with two voices.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// A register-level model tracks the shadows and predicts each transfer payload.
module tb_synth_mmio_ctrl;
  localparam int NV = 2;
  localparam int OW = 24*NV + 24 + 5 + NV + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    mmio_addr;
  logic [31:0]   mmio_wdata;
  logic          mmio_we;
  logic          mmio_re;
  logic [31:0]   mmio_rdata;
  logic [24*NV-1:0] cpu_carrier_fcws;
  logic [23:0]   cpu_mod_fcw;
  logic [4:0]    cpu_mod_shift;
  logic [NV-1:0] cpu_note_en;
  logic [4:0]    cpu_synth_shift;
  logic          cpu_req;
  logic          cpu_ack;

  int total = 0;
  int bad   = 0;

  // model of the shadow registers
  logic [23:0]   m_fcw [NV];
  logic [23:0]   m_mod_fcw;
  logic [4:0]    m_mod_shift;
  logic [NV-1:0] m_note;
  logic [4:0]    m_sshift;
  logic [OW-1:0] e_outs;

  wire [OW-1:0] act_outs = {cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en, cpu_synth_shift};

  synth_mmio_ctrl #(.N_VOICES(NV)) dut (
    .clk(clk), .rst_n(rst_n), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_rdata(mmio_rdata),
    .cpu_carrier_fcws(cpu_carrier_fcws), .cpu_mod_fcw(cpu_mod_fcw),
    .cpu_mod_shift(cpu_mod_shift), .cpu_note_en(cpu_note_en),
    .cpu_synth_shift(cpu_synth_shift), .cpu_req(cpu_req), .cpu_ack(cpu_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] shadow_cat();
    return {m_fcw[1], m_fcw[0], m_mod_fcw, m_mod_shift, m_note, m_sshift};
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NV; i++) m_fcw[i] = 24'd0;
    m_mod_fcw = 24'd0; m_mod_shift = 5'd0; m_note = '0; m_sshift = 5'd0;
  endtask

  task automatic mdl_write(input logic [7:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[7:2]);
    if (idx < NV) m_fcw[idx] = d[23:0];
    else if (idx == 16) m_mod_fcw = d[23:0];
    else if (idx == 17) m_mod_shift = d[4:0];
    else if (idx == 18) m_note = d[NV-1:0];
    else if (idx == 19) m_sshift = d[4:0];
  endtask

  function automatic logic [31:0] mdl_read(input logic [5:0] idx, input bit busy, input bit pend);
    int k;
    k = int'(idx);
    if (k < NV) return {8'd0, m_fcw[k]};
    if (k == 16) return {8'd0, m_mod_fcw};
    if (k == 17) return {27'd0, m_mod_shift};
    if (k == 18) return {30'd0, m_note};
    if (k == 19) return {27'd0, m_sshift};
    if (k == 20) return {30'd0, pend, busy};
    return 32'd0;
  endfunction

  // random word index for a shadow write, never the commit register
  function automatic logic [5:0] rand_widx();
    int k;
    k = $urandom_range(0, 30);
    if (k >= 20) k = k + 1;
    return 6'(k);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1;
    @(negedge clk);
    mmio_we = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    mmio_addr = a; mmio_re = 1'b1;
    @(negedge clk);
    mmio_re = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; cpu_ack = 1'b0; mmio_we = 1'b0; mmio_re = 1'b0;
    mmio_addr = 8'd0; mmio_wdata = 32'd0;
    repeat (4) @(negedge clk);
    mdl_reset();
    total++;
    if (act_outs !== '0 || cpu_req !== 1'b0 || mmio_rdata !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: outs=%h req=%b rdata=%h, want all 0", act_outs, cpu_req, mmio_rdata);
    end
    rst_n = 1'b1;
    rd(8'h50, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wr(8'h04, 32'h00123456);
    wr(8'h48, 32'd3);
    wr(8'h50, 32'd0);
    e_outs = shadow_cat();
    total++;
    if (cpu_req !== 1'b1 || cpu_carrier_fcws[47:24] !== 24'h123456 || cpu_note_en !== 2'b11) begin
      bad++; $display("FAIL basic_launch: req=%b fcw1=%h note=%b, want 1 123456 11", cpu_req, cpu_carrier_fcws[47:24], cpu_note_en);
    end
    total++;
    if (act_outs !== e_outs) begin bad++; $display("FAIL basic_outs: got %h want %h", act_outs, e_outs); end
    repeat (2) @(negedge clk);
    cpu_ack = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_req !== 1'b0) begin bad++; $display("FAIL basic_req_drop: req=%b want 0", cpu_req); end
    cpu_ack = 1'b0;
    @(negedge clk);
    rd(8'h50, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL basic_status: got %h want 0", d); end
  endtask

  task automatic test_stability();
    logic [31:0] d;
    logic [23:0] old_mod;
    wr(8'h50, 32'd0);
    e_outs = shadow_cat();
    old_mod = m_mod_fcw;
    wr(8'h40, 32'h00ABCDEF);
    total++;
    if (cpu_req !== 1'b1 || cpu_mod_fcw !== old_mod) begin
      bad++; $display("FAIL stable_mod_fcw: req=%b mod=%h want 1 %h", cpu_req, cpu_mod_fcw, old_mod);
    end
    rd(8'h40, d);
    total++;
    if (d !== 32'h00ABCDEF) begin bad++; $display("FAIL stable_readback: got %h want 00abcdef", d); end
    cpu_ack = 1'b1;
    @(negedge clk);
    total++;
    if (act_outs !== e_outs) begin bad++; $display("FAIL stable_outs_ack: got %h want %h", act_outs, e_outs); end
    cpu_ack = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_req !== 1'b0) begin bad++; $display("FAIL stable_end: req=%b want 0", cpu_req); end
  endtask

  task automatic test_pending();
    logic [31:0] d;
    logic [OW-1:0] first;
    wr(8'h50, 32'd0);
    first = shadow_cat();
    wr(8'h40, 32'h00112233);
    wr(8'h50, 32'd0);
    wr(8'h00, 32'h00445566);
    wr(8'h50, 32'd0);
    rd(8'h50, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL pending_status: got %h want 3", d); end
    cpu_ack = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_req !== 1'b0 || act_outs !== first) begin
      bad++; $display("FAIL pending_first: req=%b outs=%h want 0 %h", cpu_req, act_outs, first);
    end
    cpu_ack = 1'b0;
    @(negedge clk);
    e_outs = shadow_cat();
    total++;
    if (cpu_req !== 1'b1 || act_outs !== e_outs) begin
      bad++; $display("FAIL pending_relaunch: req=%b outs=%h want 1 %h", cpu_req, act_outs, e_outs);
    end
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (cpu_req !== 1'b0) begin bad++; $display("FAIL pending_extra_req: cycle %0d req=%b want 0", i, cpu_req); end
    end
    rd(8'h50, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL pending_idle: got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(8'h4C, 32'h15);
    rd(8'h4C, d);
    wr(8'h50, 32'd0);
    cpu_ack = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    mdl_reset();
    total++;
    if (cpu_req !== 1'b0 || act_outs !== '0 || mmio_rdata !== 32'd0) begin
      bad++; $display("FAIL midreset: req=%b outs=%h rdata=%h want all 0", cpu_req, act_outs, mmio_rdata);
    end
    rst_n = 1'b1;
    cpu_ack = 1'b0;
    @(negedge clk);
    wr(8'h04, 32'h00ABC123);
    wr(8'h50, 32'd0);
    e_outs = shadow_cat();
    total++;
    if (cpu_req !== 1'b1 || act_outs !== e_outs) begin
      bad++; $display("FAIL midreset_relaunch: req=%b outs=%h want 1 %h", cpu_req, act_outs, e_outs);
    end
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    @(negedge clk);
    rd(8'h50, d);
    total++;
    if (cpu_req !== 1'b0 || d !== 32'd0) begin
      bad++; $display("FAIL midreset_clean: req=%b status=%h want 0 0", cpu_req, d);
    end
  endtask

  task automatic test_width();
    logic [31:0] d;
    wr(8'h44, 32'hFFFFFFFF);
    rd(8'h44, d);
    total++;
    if (d !== 32'h1F) begin bad++; $display("FAIL width_shift: got %h want 1f", d); end
    wr(8'h08, 32'h0055AA55);
    rd(8'h08, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL unmapped_voice: got %h want 0", d); end
    rd(8'h7C, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL unmapped_7c: got %h want 0", d); end
    wr(8'h03, 32'hFFFFFFFF);
    rd(8'h01, d);
    total++;
    if (d !== 32'h00FFFFFF) begin bad++; $display("FAIL width_fcw0: got %h want 00ffffff", d); end
    mmio_addr = 8'h48; mmio_wdata = 32'h1; mmio_we = 1'b1; mmio_re = 1'b1;
    @(negedge clk);
    mmio_we = 1'b0; mmio_re = 1'b0;
    mdl_write(8'h48, 32'h1);
    total++;
    if (mmio_rdata !== 32'h00FFFFFF) begin bad++; $display("FAIL we_re_rdata: got %h want 00ffffff", mmio_rdata); end
    rd(8'h48, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL we_re_write: got %h want 1", d); end
  endtask

  task automatic test_stale_ack();
    logic [31:0] d;
    cpu_ack = 1'b1;
    repeat (2) @(negedge clk);
    wr(8'h50, 32'd0);
    e_outs = shadow_cat();
    total++;
    if (cpu_req !== 1'b1 || act_outs !== e_outs) begin
      bad++; $display("FAIL stale_launch: req=%b outs=%h want 1 %h", cpu_req, act_outs, e_outs);
    end
    @(negedge clk);
    cpu_ack = 1'b0;
    @(negedge clk);
    rd(8'h50, d);
    total++;
    if (cpu_req !== 1'b0 || d !== 32'd0) begin
      bad++; $display("FAIL stale_end: req=%b status=%h want 0 0", cpu_req, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [5:0]  idx;
    bit          pend;
    bit          again;
    int          ntx;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) wr({rand_widx(), 2'($urandom)}, $urandom);
      idx = 6'($urandom_range(0, 31));
      rd({idx, 2'($urandom)}, d);
      total++;
      if (d !== mdl_read(idx, 1'b0, 1'b0)) begin
        bad++; $display("FAIL rand_idle_read: it=%0d idx=%0d got %h want %h", it, idx, d, mdl_read(idx, 1'b0, 1'b0));
      end
      wr(8'h50, $urandom);
      e_outs = shadow_cat();
      pend = 1'b0;
      ntx = 0;
      total++;
      if (cpu_req !== 1'b1 || act_outs !== e_outs) begin
        bad++; $display("FAIL rand_launch: it=%0d req=%b outs=%h want 1 %h", it, cpu_req, act_outs, e_outs);
      end
      do begin
        ntx++;
        repeat ($urandom_range(0, 3)) begin
          case ($urandom_range(0, 2))
            0: begin
              if (ntx < 3) begin wr(8'h50, $urandom); pend = 1'b1; end
              else wr({rand_widx(), 2'b00}, $urandom);
            end
            1: wr({rand_widx(), 2'b00}, $urandom);
            default: begin
              rd(8'h50, d);
              total++;
              if (d !== {30'd0, pend, 1'b1}) begin
                bad++; $display("FAIL rand_status: it=%0d got %h want %h", it, d, {30'd0, pend, 1'b1});
              end
            end
          endcase
          total++;
          if (cpu_req !== 1'b1 || act_outs !== e_outs) begin
            bad++; $display("FAIL rand_req_hold: it=%0d req=%b outs=%h want 1 %h", it, cpu_req, act_outs, e_outs);
          end
        end
        cpu_ack = 1'b1;
        @(negedge clk);
        total++;
        if (cpu_req !== 1'b0 || act_outs !== e_outs) begin
          bad++; $display("FAIL rand_ack: it=%0d req=%b outs=%h want 0 %h", it, cpu_req, act_outs, e_outs);
        end
        repeat ($urandom_range(0, 2)) begin
          if (ntx < 3 && $urandom_range(0, 3) == 0) begin wr(8'h50, $urandom); pend = 1'b1; end
          else wr({rand_widx(), 2'b00}, $urandom);
          total++;
          if (cpu_req !== 1'b0 || act_outs !== e_outs) begin
            bad++; $display("FAIL rand_release_hold: it=%0d req=%b outs=%h want 0 %h", it, cpu_req, act_outs, e_outs);
          end
        end
        cpu_ack = 1'b0;
        @(negedge clk);
        again = pend;
        if (pend) begin
          e_outs = shadow_cat();
          pend = 1'b0;
        end
        total++;
        if (cpu_req !== again || act_outs !== e_outs) begin
          bad++; $display("FAIL rand_close: it=%0d req=%b outs=%h want %b %h", it, cpu_req, act_outs, again, e_outs);
        end
      end while (again);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stability();
    test_pending();
    test_reset_mid();
    test_width();
    test_stale_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
